// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, twiddle constants and saturation helper for the FFT datapath
package fft_pkg;
  localparam int DW_DEF = 17;
  localparam int TW_DEF = 8;
  localparam int TAG_W_DEF = 4;
  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;
  function automatic int twiddle_one(int tw);
    return 1 << (tw - 2);
  endfunction
  function automatic int round_half(int tw);
    return 1 << (tw - 3);
  endfunction
  // clamp a wide signed value to the w-bit signed range
  function automatic logic signed [63:0] sat(logic signed [63:0] v, int w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    return v > hi ? hi : (v < -hi - 64'sd1 ? -hi - 64'sd1 : v);
  endfunction
endpackage

// File: rtl/fft_bfly_r2_pipe_if.sv
// fft_bfly_r2_pipe_if: stream handshake, operand/result buses and overflow control of one butterfly lane
interface fft_bfly_r2_pipe_if import fft_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF,
  parameter int TAG_W = TAG_W_DEF
);
  logic in_valid, in_ready, inv, scale, out_valid, out_ready, ovf, ovf_clr;
  logic signed [DW-1:0] a_re, a_im, b_re, b_im, x_re, x_im, y_re, y_im;
  logic signed [TW-1:0] w_re, w_im;
  logic [TAG_W-1:0] tag_in, tag_out;
  modport master (
    output in_valid, a_re, a_im, b_re, b_im, w_re, w_im, inv, scale, tag_in, out_ready, ovf_clr,
    input  in_ready, out_valid, x_re, x_im, y_re, y_im, tag_out, ovf
  );
  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, w_re, w_im, inv, scale, tag_in, out_ready, ovf_clr,
    output in_ready, out_valid, x_re, x_im, y_re, y_im, tag_out, ovf
  );
endinterface

// File: rtl/fft_cmul_pipe.sv
// fft_cmul_pipe: two-stage enable-gated complex multiply B*W or B*conj(W) with half-up rounding and sideband
module fft_cmul_pipe import fft_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF,
  parameter int SW = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 vld_i,
  input  logic                 conj_i,
  input  logic signed [DW-1:0] b_re_i,
  input  logic signed [DW-1:0] b_im_i,
  input  logic signed [TW-1:0] w_re_i,
  input  logic signed [TW-1:0] w_im_i,
  input  logic [SW-1:0]        sb_i,
  output logic                 vld_o,
  output logic signed [DW:0]   p_re_o,
  output logic signed [DW:0]   p_im_o,
  output logic [SW-1:0]        sb_o
);
  localparam int PW = DW + TW;
  localparam int RND = round_half(TW);
  logic signed [TW-1:0] w_im_c;
  logic signed [PW-1:0] rr_q, ii_q, ri_q, ir_q;
  logic signed [DW:0] p_re_d, p_im_d, p_re_q, p_im_q;
  logic v1_q, v2_q;
  logic [SW-1:0] sb1_q, sb2_q;
  // |W| <= 1 keeps the rounded product inside DW+1 bits, so the top bits are dropped safely
  always_comb begin
    w_im_c = conj_i ? -w_im_i : w_im_i;
    p_re_d = (DW+1)'(((PW+1)'(rr_q) - (PW+1)'(ii_q) + (PW+1)'(RND)) >>> (TW - 2));
    p_im_d = (DW+1)'(((PW+1)'(ri_q) + (PW+1)'(ir_q) + (PW+1)'(RND)) >>> (TW - 2));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else if (en_i) begin
      v1_q <= vld_i;
      v2_q <= v1_q;
    end
    if (en_i) begin
      rr_q <= PW'(b_re_i) * PW'(w_re_i);
      ii_q <= PW'(b_im_i) * PW'(w_im_c);
      ri_q <= PW'(b_re_i) * PW'(w_im_c);
      ir_q <= PW'(b_im_i) * PW'(w_re_i);
      sb1_q <= sb_i;
      p_re_q <= p_re_d;
      p_im_q <= p_im_d;
      sb2_q <= sb1_q;
    end
  end
  assign vld_o = v2_q;
  assign p_re_o = p_re_q;
  assign p_im_o = p_im_q;
  assign sb_o = sb2_q;
endmodule

// File: rtl/fft_bfly_r2_pipe.sv
// fft_bfly_r2_pipe: pipelined radix-2 DIT butterfly lane (A +/- W*B) with scaling, saturation and sticky overflow
module fft_bfly_r2_pipe import fft_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input logic               clk,
  input logic               rst,
  fft_bfly_r2_pipe_if.slave bus
);
  localparam int SW = 2 * DW + 1 + TAG_W;
  logic adv, v2, sc2, any_sat, out_valid_q, ovf_q;
  logic [SW-1:0] sb_in, sb2;
  logic signed [DW-1:0] a_re2, a_im2;
  logic [TAG_W-1:0] tag2, tag_q;
  logic signed [DW:0] p_re, p_im;
  logic signed [DW+1:0] s_re, s_im, d_re, d_im;
  logic signed [DW-1:0] x_re_d, x_im_d, y_re_d, y_im_d, x_re_q, x_im_q, y_re_q, y_im_q;
  assign sb_in = {bus.a_re, bus.a_im, bus.scale, bus.tag_in};
  assign {a_re2, a_im2, sc2, tag2} = sb2;
  fft_cmul_pipe #(.DW(DW), .TW(TW), .SW(SW)) u_cmul (
    .clk(clk), .rst(rst), .en_i(adv), .vld_i(bus.in_valid), .conj_i(bus.inv),
    .b_re_i(bus.b_re), .b_im_i(bus.b_im), .w_re_i(bus.w_re), .w_im_i(bus.w_im), .sb_i(sb_in),
    .vld_o(v2), .p_re_o(p_re), .p_im_o(p_im), .sb_o(sb2)
  );
  always_comb begin
    adv = bus.out_ready | ~out_valid_q;
    s_re = ((DW+2)'(a_re2) + (DW+2)'(p_re)) >>> sc2;
    s_im = ((DW+2)'(a_im2) + (DW+2)'(p_im)) >>> sc2;
    d_re = ((DW+2)'(a_re2) - (DW+2)'(p_re)) >>> sc2;
    d_im = ((DW+2)'(a_im2) - (DW+2)'(p_im)) >>> sc2;
    x_re_d = DW'(sat(64'(s_re), DW));
    x_im_d = DW'(sat(64'(s_im), DW));
    y_re_d = DW'(sat(64'(d_re), DW));
    y_im_d = DW'(sat(64'(d_im), DW));
    any_sat = (s_re != (DW+2)'(x_re_d)) | (s_im != (DW+2)'(x_im_d)) |
              (d_re != (DW+2)'(y_re_d)) | (d_im != (DW+2)'(y_im_d));
  end
  // ovf only sees samples actually loaded into the output register; set beats clear
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ovf_q <= 1'b0;
      x_re_q <= '0;
      x_im_q <= '0;
      y_re_q <= '0;
      y_im_q <= '0;
      tag_q <= '0;
    end else begin
      if (adv) begin
        out_valid_q <= v2;
        x_re_q <= x_re_d;
        x_im_q <= x_im_d;
        y_re_q <= y_re_d;
        y_im_q <= y_im_d;
        tag_q <= tag2;
      end
      ovf_q <= (adv & v2 & any_sat) | (ovf_q & ~bus.ovf_clr);
    end
  end
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.x_re = x_re_q;
  assign bus.x_im = x_im_q;
  assign bus.y_re = y_re_q;
  assign bus.y_im = y_im_q;
  assign bus.tag_out = tag_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_fft_bfly_r2_pipe.sv
// tb_fft_bfly_r2_pipe: directed and randomized checks of the butterfly lane against a plain-arithmetic reference
module tb_fft_bfly_r2_pipe;
  import fft_pkg::*;
  typedef struct {
    int tag, xr, xi, yr, yi;
    bit sat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fft_bfly_r2_pipe_if #(.DW(17), .TW(8), .TAG_W(4)) bus ();
  fft_bfly_r2_pipe #(.DW(17), .TW(8), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  bit armed = 0, held = 0, prev_clr = 0, prev_rst = 0, exp_ovf = 0, rand_bp = 0;

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic int fdiv(longint n, longint d);
    return int'(n >= 0 ? n / d : -((-n + d - 1) / d));
  endfunction

  // reference: exact complex product, round half-up to Q0, butterfly, optional floor halving, clamp
  function automatic exp_t model(int ar, int ai, int br, int bi, int wr, int wi, bit inv, bit sc, int tag);
    exp_t e;
    longint w2, pr, pi;
    int bpr, bpi;
    int v[4];
    w2 = inv ? -longint'(wi) : longint'(wi);
    pr = longint'(br) * longint'(wr) - longint'(bi) * w2;
    pi = longint'(br) * w2 + longint'(bi) * longint'(wr);
    bpr = fdiv(pr + 32, 64);
    bpi = fdiv(pi + 32, 64);
    v = '{ar + bpr, ai + bpi, ar - bpr, ai - bpi};
    e.sat = 0;
    foreach (v[i]) begin
      if (sc) v[i] = fdiv(longint'(v[i]), 2);
      if (v[i] > 65535) begin v[i] = 65535; e.sat = 1; end
      if (v[i] < -65536) begin v[i] = -65536; e.sat = 1; end
    end
    e.xr = v[0]; e.xi = v[1]; e.yr = v[2]; e.yi = v[3]; e.tag = tag;
    return e;
  endfunction

  task automatic pin(string n, exp_t e, int xr, int xi, int yr, int yi, int s);
    chk({n, "_xr"}, e.xr, xr);
    chk({n, "_xi"}, e.xi, xi);
    chk({n, "_yr"}, e.yr, yr);
    chk({n, "_yi"}, e.yi, yi);
    chk({n, "_sat"}, int'(e.sat), s);
  endtask

  always @(negedge clk) if (armed) begin
    if (rst) begin
      q.delete();
      held = 0;
      prev_rst = 1;
    end else begin
      exp_ovf = prev_rst ? 1'b0 :
                (bus.out_valid && !held && q.size() > 0 && q[0].sat) ? 1'b1 :
                prev_clr ? 1'b0 : exp_ovf;
      chk("ovf", int'(bus.ovf), int'(exp_ovf));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_spurious: got tag %0d, expected no output", bus.tag_out);
        end else begin
          chk("tag", int'(bus.tag_out), q[0].tag);
          chk("x_re", int'(bus.x_re), q[0].xr);
          chk("x_im", int'(bus.x_im), q[0].xi);
          chk("y_re", int'(bus.y_re), q[0].yr);
          chk("y_im", int'(bus.y_im), q[0].yi);
          if (bus.out_ready) void'(q.pop_front());
        end
      end
      held = bus.out_valid && !bus.out_ready;
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(int'(bus.a_re), int'(bus.a_im), int'(bus.b_re), int'(bus.b_im),
                          int'(bus.w_re), int'(bus.w_im), bus.inv, bus.scale, int'(bus.tag_in)));
      prev_rst = 0;
    end
    prev_clr = bus.ovf_clr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) begin
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.ovf_clr = $urandom_range(0, 7) == 0;
    end
  endtask

  task automatic set_vals(int ar, int ai, int br, int bi, int wr, int wi, bit inv, bit sc, int tag);
    bus.a_re = 17'(ar); bus.a_im = 17'(ai);
    bus.b_re = 17'(br); bus.b_im = 17'(bi);
    bus.w_re = 8'(wr); bus.w_im = 8'(wi);
    bus.inv = inv; bus.scale = sc; bus.tag_in = 4'(tag);
    bus.in_valid = 1;
  endtask

  task automatic set_in(int tag, bit inv, bit sc);
    int wr, wi;
    do begin
      wr = int'($urandom_range(0, 128)) - 64;
      wi = int'($urandom_range(0, 128)) - 64;
    end while (wr * wr + wi * wi > 4096);
    set_vals(int'($urandom_range(0, 131071)) - 65536, int'($urandom_range(0, 131071)) - 65536,
             int'($urandom_range(0, 131071)) - 65536, int'($urandom_range(0, 131071)) - 65536,
             wr, wi, inv, sc, tag);
  endtask

  task automatic one(int ar, int ai, int br, int bi, int wr, int wi, bit inv, bit sc, int tag,
                     int xr, int xi, int yr, int yi);
    int k = 0;
    set_vals(ar, ai, br, bi, wr, wi, inv, sc, tag);
    @(negedge clk);
    chk("dir_in_ready", int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.out_valid && k < 10);
    chk("dir_latency", k, 3);
    chk("dir_x_re", int'(bus.x_re), xr);
    chk("dir_x_im", int'(bus.x_im), xi);
    chk("dir_y_re", int'(bus.y_re), yr);
    chk("dir_y_im", int'(bus.y_im), yi);
    chk("dir_tag", int'(bus.tag_out), tag);
    tick();
  endtask

  task automatic drain(string name);
    bus.in_valid = 0;
    repeat (8) tick();
    chk(name, q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, last;
    bit acc;
    set_vals(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 0;
    bus.out_ready = 1;
    bus.ovf_clr = 0;
    pin("m_id", model(100, 50, 20, -10, 64, 0, 0, 0, 0), 120, 40, 80, 60, 0);
    pin("m_mj", model(100, 50, 20, -10, 0, -64, 0, 0, 0), 90, 30, 110, 70, 0);
    pin("m_mj_inv", model(100, 50, 20, -10, 0, -64, 1, 0, 0), 110, 70, 90, 30, 0);
    pin("m_sat", model(65535, 0, 65535, 0, 64, 0, 0, 0, 0), 65535, 0, 0, 0, 1);
    pin("m_sat_sc", model(65535, 0, 65535, 0, 64, 0, 0, 1, 0), 65535, 0, 0, 0, 0);
    pin("m_floor", model(-3, 0, 0, 0, 64, 0, 0, 1, 0), -2, 0, -2, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    armed = 1;
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_x_re", int'(bus.x_re), 0);
    chk("rst_y_im", int'(bus.y_im), 0);
    chk("rst_tag", int'(bus.tag_out), 0);
    tick();
    one(100, 50, 20, -10, 64, 0, 0, 0, 5, 120, 40, 80, 60);
    one(100, 50, 20, -10, 0, -64, 0, 0, 6, 90, 30, 110, 70);
    one(100, 50, 20, -10, 0, -64, 1, 0, 7, 110, 70, 90, 30);
    one(-3, 0, 0, 0, 64, 0, 0, 1, 3, -2, 0, -2, 0);
    one(65535, 0, 65535, 0, 64, 0, 0, 0, 1, 65535, 0, 0, 0);
    @(negedge clk);
    chk("sat_ovf_set", int'(bus.ovf), 1);
    tick();
    bus.ovf_clr = 1;
    tick();
    bus.ovf_clr = 0;
    @(negedge clk);
    chk("ovf_cleared", int'(bus.ovf), 0);
    tick();
    one(65535, 0, 65535, 0, 64, 0, 0, 1, 2, 65535, 0, 0, 0);
    @(negedge clk);
    chk("scaled_no_ovf", int'(bus.ovf), 0);
    tick();
    drain("drain_directed");
    bus.out_ready = 0;
    k = 0;
    last = -1;
    for (int c = 0; c < 40 && k < 8; c++) begin
      if (k != last) begin
        set_in(k, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        last = k;
      end
      @(negedge clk);
      if (c == 2) chk("bp_ready_before_full", int'(bus.in_ready), 1);
      if (c == 3) chk("bp_ready_when_full", int'(bus.in_ready), 0);
      if (bus.in_ready) k++;
      tick();
      if (c == 4) bus.out_ready = 1;
    end
    bus.in_valid = 0;
    chk("bp_all_sent", k, 8);
    drain("drain_backpressure");
    for (int i = 0; i < 16; i++) begin
      set_in(i, bit'(i & 1), bit'((i >> 1) & 1));
      @(negedge clk);
      chk("full_rate_ready", int'(bus.in_ready), 1);
      tick();
    end
    drain("drain_interleaved");
    rand_bp = 1;
    acc = 0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.in_valid || acc) begin
        if ($urandom_range(0, 3) != 0)
          set_in(c & 15, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        else
          bus.in_valid = 0;
      end
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      tick();
    end
    rand_bp = 0;
    bus.out_ready = 1;
    bus.ovf_clr = 0;
    drain("drain_random");
    one(65535, 0, 65535, 0, 64, 0, 0, 0, 9, 65535, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      set_in(i, 0, 0);
      tick();
    end
    bus.in_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("pre_rst_ovf", int'(bus.ovf), 1);
    chk("pre_rst_valid", int'(bus.out_valid), 1);
    tick();
    rst = 0;
    @(negedge clk);
    chk("post_rst_valid", int'(bus.out_valid), 0);
    chk("post_rst_ovf", int'(bus.ovf), 0);
    tick();
    one(100, 50, 20, -10, 64, 0, 0, 0, 4, 120, 40, 80, 60);
    drain("drain_after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
